cpu_run_ctrl: RTL
=================

CPU_RUN_CTRL -- requirements
Module: cpu_run_ctrl

Interface
REQ-001 Parameters SHALL be: PC_W, 32, PC width; PRE_CYC, 2, cycles before core reset; RST_CYC, 2, core-reset pulse length; POST_CYC, 2, settle cycles after reset; MAX_CYC, 1000, run-cycle limit; HALT_WIN, 8, halt-detect window; CNT_W, 16, cycle-counter width.
REQ-002 Port clk SHALL be input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 Port rst SHALL be input, 1 bit: asynchronous, active-high reset.
REQ-004 Port restart SHALL be input, 1 bit: request a new run sequence; honoured only in DONE.
REQ-005 Port pc_in SHALL be input, PC_W bits: the core's next-PC value.
REQ-006 Port pc_write SHALL be input, 1 bit: core PC-write enable; 0 means a hazard stall.
REQ-007 Port cpu_rst SHALL be output, 1 bit: reset to the core under control.
REQ-008 Port run SHALL be output, 1 bit: high while in RUN.
REQ-009 Port done SHALL be output, 1 bit: high while in DONE.
REQ-010 Port timeout SHALL be output, 1 bit: sticky flag, run ended by the cycle limit.
REQ-011 Port halted SHALL be output, 1 bit: sticky flag, run ended by halt detect.
REQ-012 Port cycle_cnt SHALL be output, CNT_W bits: RUN cycles elapsed.

Function
REQ-013 FSM states SHALL be PRE, CORE_RST, SETTLE, RUN and DONE; all outputs are Moore, decoded from registers.
REQ-014 PRE SHALL last PRE_CYC cycles, then go to CORE_RST; cpu_rst=0.
REQ-015 CORE_RST SHALL assert cpu_rst=1 for exactly RST_CYC cycles, then go to SETTLE.
REQ-016 SETTLE SHALL hold cpu_rst=0 for POST_CYC cycles, then go to RUN.
REQ-017 A phase parameter of 0 SHALL skip that state with no extra cycle; RST_CYC=0 SHALL be illegal (elaboration error).
REQ-018 In RUN, cycle_cnt SHALL increment by 1 per cycle, starting from 0 on RUN entry.
REQ-019 When cycle_cnt reaches MAX_CYC, timeout SHALL set and the FSM SHALL enter DONE on the same edge.
REQ-020 MAX_CYC SHALL be no greater than 2^CNT_W-1; otherwise an elaboration error is raised; cycle_cnt never wraps.
REQ-021 Halt detect SHALL register pc_prev every RUN cycle in which pc_write=1.
REQ-022 The stable counter SHALL increment when pc_write=1 and pc_in==pc_prev, clear when pc_write=1 and pc_in!=pc_prev, and hold when pc_write=0.
REQ-023 When the stable counter reaches HALT_WIN, halted SHALL set and the FSM SHALL enter DONE.
REQ-024 Timeout and halt detected on the same edge SHALL set both flags.
REQ-025 In DONE, run=0, done=1, cpu_rst=0; cycle_cnt and both flags SHALL freeze.
REQ-026 restart=1 in DONE SHALL clear cycle_cnt, the flags, pc_prev and the stable counter, and go to PRE on the next edge.
REQ-027 restart SHALL be ignored in every state other than DONE.

Reset
REQ-028 rst=1 SHALL force, asynchronously: state PRE, all counters 0, pc_prev 0, cpu_rst=0, run=0, done=0, timeout=0, halted=0.
REQ-029 rst asserted mid-sequence or mid-RUN SHALL abort the sequence; after release, the full PRE, CORE_RST, SETTLE sequence SHALL restart.

Configuration
REQ-030 Macro CPU_RUN_CTRL_HALT_DET_EN defined SHALL include the halt-detect logic of REQ-021 to REQ-024.
REQ-031 Without CPU_RUN_CTRL_HALT_DET_EN, halted SHALL be tied 0, no pc_prev or stable-counter registers SHALL exist, and only timeout ends a run.

Verification
REQ-032 Defaults, rst released, pc_in incrementing by 4 -> cpu_rst high on edges 3-4, run from edge 7, timeout=1 and done=1 when cycle_cnt=1000.
REQ-033 HALT_DET_EN, pc_in held at 0x40 with pc_write=1 from RUN cycle 20 -> halted=1 and done=1 after 8 equal cycles, cycle_cnt=28 frozen.
REQ-034 pc_in held at 0x40 with pc_write toggling 1/0 -> stall cycles hold the stable count; halted=1 only after 8 write cycles.
REQ-035 MAX_CYC=10 with PC constant from RUN entry and HALT_WIN=10 -> timeout=1 and halted=1 on the same edge.
REQ-036 rst pulsed while in RUN at cycle_cnt=50 -> all outputs 0 immediately; after release, the sequence restarts and cpu_rst pulses again.
REQ-037 In DONE, restart=1 for 1 cycle -> flags and cycle_cnt cleared next edge, state PRE; restart=1 during RUN -> no effect.

Source files
------------

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: core reset sequencer and run supervisor (PRE/CORE_RST/SETTLE/RUN/DONE).
// Optional halt detect via `define CPU_RUN_CTRL_HALT_DET_EN; default build ends runs on timeout only.
module cpu_run_ctrl #(
  parameter int PC_W     = 32,
  parameter int PRE_CYC  = 2,
  parameter int RST_CYC  = 2,
  parameter int POST_CYC = 2,
  parameter int MAX_CYC  = 1000,
  parameter int HALT_WIN = 8,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             restart,
  input  logic [PC_W-1:0]  pc_in,
  input  logic             pc_write,
  output logic             cpu_rst,
  output logic             run,
  output logic             done,
  output logic             timeout,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_cnt
);

  typedef enum logic [2:0] {
    S_PRE, S_CRST, S_SETTLE, S_RUN, S_DONE
  } state_t;

  localparam int PH_MAX0 = (PRE_CYC > RST_CYC) ? PRE_CYC : RST_CYC;
  localparam int PH_MAX  = (PH_MAX0 > POST_CYC) ? PH_MAX0 : POST_CYC;
  localparam int PH_W    = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam logic [PH_W-1:0] PRE_LAST =
    PH_W'((PRE_CYC > 0) ? PRE_CYC - 1 : 0);
  localparam logic [PH_W-1:0] RST_LAST =
    PH_W'((RST_CYC > 0) ? RST_CYC - 1 : 0);
  localparam logic [PH_W-1:0] POST_LAST =
    PH_W'((POST_CYC > 0) ? POST_CYC - 1 : 0);
  localparam logic [CNT_W-1:0] MAX_V = CNT_W'(MAX_CYC);

  if (RST_CYC == 0) begin : g_rst_chk
    $error("cpu_run_ctrl: RST_CYC must be nonzero");
  end
  if (longint'(MAX_CYC) > (longint'(1) << CNT_W) - 1) begin : g_max_chk
    $error("cpu_run_ctrl: MAX_CYC exceeds cycle counter range");
  end

  state_t           state_q, state_d;
  logic [PH_W-1:0]  ph_q, ph_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             to_q, to_d;
  logic             cpu_rst_q, run_q, done_q;
  logic             halt_hit;

`ifdef CPU_RUN_CTRL_HALT_DET_EN
  localparam int SW = $clog2(HALT_WIN + 1);

  logic [PC_W-1:0] pc_prev_q, pc_prev_d;
  logic [SW-1:0]   stab_q, stab_d, stab_nx;
  logic            ht_q, ht_d;

  // Stable-PC window: stalls hold the count, new PCs clear it
  always_comb begin
    pc_prev_d = pc_prev_q;
    stab_d    = stab_q;
    ht_d      = ht_q;
    halt_hit  = 1'b0;
    stab_nx   = (pc_in == pc_prev_q) ? stab_q + 1'b1 : '0;
    if (state_q == S_RUN && pc_write) begin
      pc_prev_d = pc_in;
      stab_d    = stab_nx;
      if (stab_nx == SW'(HALT_WIN)) begin
        halt_hit = 1'b1;
        ht_d     = 1'b1;
      end
    end else if (state_q == S_DONE && restart) begin
      pc_prev_d = '0;
      stab_d    = '0;
      ht_d      = 1'b0;
    end
  end

  // Halt-detect registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_prev_q <= '0;
      stab_q    <= '0;
      ht_q      <= 1'b0;
    end else begin
      pc_prev_q <= pc_prev_d;
      stab_q    <= stab_d;
      ht_q      <= ht_d;
    end
  end

  assign halted = ht_q;
`else
  logic unused_pc;
  assign unused_pc = ^{pc_in, pc_write};
  assign halt_hit  = 1'b0;
  assign halted    = 1'b0;
`endif

  // Sequencer next state, phase timer and run counter
  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    cnt_d   = cnt_q;
    to_d    = to_q;
    cnt_inc = cnt_q + 1'b1;
    unique case (state_q)
      S_PRE: begin
        if (ph_q == PRE_LAST) begin
          ph_d    = '0;
          state_d = S_CRST;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      S_CRST: begin
        if (ph_q == RST_LAST) begin
          ph_d    = '0;
          state_d = (POST_CYC == 0) ? S_RUN : S_SETTLE;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      S_SETTLE: begin
        if (ph_q == POST_LAST) begin
          ph_d    = '0;
          state_d = S_RUN;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      S_RUN: begin
        cnt_d = cnt_inc;
        if (cnt_inc >= MAX_V) begin
          to_d    = 1'b1;
          state_d = S_DONE;
        end
        if (halt_hit) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (restart) begin
          state_d = S_PRE;
          ph_d    = '0;
          cnt_d   = '0;
          to_d    = 1'b0;
        end
      end
      default: begin
        state_d = S_PRE;
        ph_d    = '0;
      end
    endcase
  end

  // State, counters and registered Moore outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_PRE;
      ph_q      <= '0;
      cnt_q     <= '0;
      to_q      <= 1'b0;
      cpu_rst_q <= 1'b0;
      run_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ph_q      <= ph_d;
      cnt_q     <= cnt_d;
      to_q      <= to_d;
      cpu_rst_q <= (state_d == S_CRST);
      run_q     <= (state_d == S_RUN);
      done_q    <= (state_d == S_DONE);
    end
  end

  assign cpu_rst   = cpu_rst_q;
  assign run       = run_q;
  assign done      = done_q;
  assign timeout   = to_q;
  assign cycle_cnt = cnt_q;

endmodule
